// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 1-D convolution datapath: loads the x vector, steps P MAC lanes through
// G output groups, and hands each group's lane results out over a valid/ready port.
module conv_seq_ctrl #(
  parameter int N = 96,
  parameter int M = 65,
  parameter int P = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 xmem_wr_en,
  output logic [$clog2(N)-1:0] xmem_wr_addr,
  output logic [$clog2(N)-1:0] xmem_rd_addr,
  output logic [$clog2(M)-1:0] fmem_rd_addr,
  output logic                 acc_en,
  output logic                 acc_clr,
  output logic [$clog2(P)-1:0] out_lane,
  output logic                 y_valid,
  input  logic                 y_ready
);

  localparam int AW = $clog2(N);
  localparam int FW = $clog2(M);
  localparam int LW = $clog2(P);
  localparam int G  = (N - M + 1) / P;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ld_q, ld_d;
  logic [FW-1:0] k_q, k_d;
  logic [GW-1:0] g_q, g_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    k_d     = k_q;
    g_d     = g_q;
    lane_d  = lane_q;
    // Memory reads take one cycle, so the MAC enables trail the address by one stage.
    en_d    = (state_q == COMPUTE);
    clr_d   = (state_q == COMPUTE) && (k_q == '0);
    case (state_q)
      LOAD: begin
        if (xmem_wr_en) begin
          ld_d = ld_q + AW'(1);
          if (ld_q == AW'(N - 1)) begin
            state_d = COMPUTE;
            ld_d    = '0;
            k_d     = '0;
            g_d     = '0;
          end
        end
      end
      COMPUTE: begin
        k_d = k_q + FW'(1);
        if (k_q == FW'(M - 1)) begin
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUTPUT;
        lane_d  = '0;
      end
      OUTPUT: begin
        if (y_ready) begin
          lane_d = lane_q + LW'(1);
          if (lane_q == LW'(P - 1)) begin
            lane_d = '0;
            if (g_q == GW'(G - 1)) begin
              g_d     = '0;
              state_d = LOAD;
            end else begin
              g_d     = g_q + GW'(1);
              k_d     = '0;
              state_d = COMPUTE;
            end
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      ld_q    <= '0;
      k_q     <= '0;
      g_q     <= '0;
      lane_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      k_q     <= k_d;
      g_q     <= g_d;
      lane_q  <= lane_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  // Handshake-facing outputs are forced low during reset so nothing is accepted or offered.
  assign x_ready      = (state_q == LOAD) && !reset;
  assign xmem_wr_en   = x_valid && x_ready;
  assign xmem_wr_addr = (state_q == LOAD) ? ld_q : '0;
  assign xmem_rd_addr = (state_q == COMPUTE) ? (AW'(g_q) * AW'(P) + AW'(k_q)) : '0;
  assign fmem_rd_addr = (state_q == COMPUTE) ? k_q : '0;
  assign acc_en       = en_q;
  assign acc_clr      = clr_q;
  assign out_lane     = (state_q == OUTPUT) ? lane_q : '0;
  assign y_valid      = (state_q == OUTPUT) && !reset;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: reset/handshake table, fixed-timing sweep,
// randomised handshakes and a mid-compute reset.
module tb_conv_seq_ctrl;
  localparam int N = 96;
  localparam int M = 65;
  localparam int P = 16;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset, x_valid, y_ready;
  logic       x_ready, xmem_wr_en, acc_en, acc_clr, y_valid;
  logic [6:0] xmem_wr_addr, xmem_rd_addr, fmem_rd_addr;
  logic [3:0] out_lane;

  int checks = 0;
  int failures = 0;

  conv_seq_ctrl #(.N(N), .M(M), .P(P)) dut (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x_ready(x_ready),
    .xmem_wr_en(xmem_wr_en), .xmem_wr_addr(xmem_wr_addr), .xmem_rd_addr(xmem_rd_addr),
    .fmem_rd_addr(fmem_rd_addr), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_lane(out_lane), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, xv, yr;
    int   e_xr, e_we, e_wa, e_yv, e_ae;
  } vec_t;
  vec_t tbl[11];

  // One whole vector: load N values, then take G*P outputs, with optional random handshakes.
  task automatic run_vector(input bit rand_x, input bit rand_y);
    int nw, hs, budget, prev_lane;
    bit prev_stall;
    nw = 0; budget = 0;
    while (nw < N && budget < 2000) begin
      x_valid = rand_x ? 1'($urandom_range(1)) : 1'b1;
      #1;
      chk("ld_x_ready", x_ready, 1);
      chk("ld_wr_en", xmem_wr_en, x_valid);
      chk("ld_wr_addr", xmem_wr_addr, nw);
      if (x_valid) nw++;
      cyc();
      budget++;
    end
    chk("ld_count", nw, N);
    x_valid = 1'b1;
    #1;
    chk("post_ld_x_ready", x_ready, 0);
    chk("post_ld_wr_en", xmem_wr_en, 0);
    hs = 0; budget = 0; prev_stall = 0; prev_lane = 0;
    while (hs < G * P && budget < 3000) begin
      x_valid = 1'($urandom_range(1));
      y_ready = rand_y ? 1'($urandom_range(1)) : 1'b1;
      #1;
      chk("busy_x_ready", x_ready, 0);
      chk("busy_wr_en", xmem_wr_en, 0);
      if (prev_stall) begin
        chk("stall_y_valid", y_valid, 1);
        chk("stall_lane", out_lane, prev_lane);
      end
      if (y_valid) begin
        chk("out_lane", out_lane, hs % P);
        prev_stall = !y_ready;
        prev_lane  = out_lane;
        if (y_ready) hs++;
      end else begin
        chk("idle_lane", out_lane, 0);
        prev_stall = 0;
      end
      cyc();
      budget++;
    end
    chk("y_handshakes", hs, G * P);
    y_ready = 1'b0;
    x_valid = 1'b0;
    #1;
    chk("back_to_load", x_ready, 1);
    chk("back_y_valid", y_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // rst, xv, yr, x_ready, wr_en, wr_addr, y_valid, acc_en
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1, 1, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1, 0, 2, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1, 0, 2, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1, 1, 2, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 0, 0, 3, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 0};

    reset = 1'b1; x_valid = 1'b0; y_ready = 1'b0;
    cyc(); cyc();

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; x_valid = tbl[i].xv; y_ready = tbl[i].yr;
      #1;
      chk("tbl_x_ready", x_ready, tbl[i].e_xr);
      chk("tbl_wr_en", xmem_wr_en, tbl[i].e_we);
      chk("tbl_wr_addr", xmem_wr_addr, tbl[i].e_wa);
      chk("tbl_y_valid", y_valid, tbl[i].e_yv);
      chk("tbl_acc_en", acc_en, tbl[i].e_ae);
      cyc();
    end

    reset = 1'b1; x_valid = 1'b0; y_ready = 1'b0;
    cyc();
    reset = 1'b0;

    // Steady load, then exact compute/drain/output timeline for both groups.
    for (int i = 0; i < N; i++) begin
      x_valid = 1'b1;
      #1;
      chk("t1_wr_en", xmem_wr_en, 1);
      chk("t1_wr_addr", xmem_wr_addr, i);
      cyc();
    end
    begin
      int clr_cnt;
      clr_cnt = 0;
      for (int g = 0; g < G; g++) begin
        for (int k = 0; k < M; k++) begin
          #1;
          chk("t1_x_ready", x_ready, 0);
          chk("t1_wr_en_busy", xmem_wr_en, 0);
          chk("t1_rd_addr", xmem_rd_addr, g * P + k);
          chk("t1_fmem_addr", fmem_rd_addr, k);
          chk("t1_acc_en", acc_en, (k != 0) ? 1 : 0);
          chk("t1_acc_clr", acc_clr, (k == 1) ? 1 : 0);
          chk("t1_y_valid_cmp", y_valid, 0);
          if (acc_clr) clr_cnt++;
          cyc();
        end
        #1;
        chk("t1_drain_acc_en", acc_en, 1);
        chk("t1_drain_acc_clr", acc_clr, 0);
        chk("t1_drain_rd_addr", xmem_rd_addr, 0);
        chk("t1_drain_y_valid", y_valid, 0);
        cyc();
        y_ready = 1'b1;
        for (int l = 0; l < P; l++) begin
          #1;
          chk("t2_y_valid", y_valid, 1);
          chk("t2_out_lane", out_lane, l);
          chk("t2_rd_addr", xmem_rd_addr, 0);
          cyc();
        end
      end
      chk("t1_clr_count", clr_cnt, G);
    end
    y_ready = 1'b0; x_valid = 1'b0;
    #1;
    chk("t2_x_ready_back", x_ready, 1);
    chk("t2_y_valid_off", y_valid, 0);
    chk("t2_wr_addr_zero", xmem_wr_addr, 0);

    // Random y_ready, then random x_valid, then both.
    run_vector(1'b0, 1'b1);
    run_vector(1'b1, 1'b0);
    run_vector(1'b1, 1'b1);

    // Reset in group 1 at k=30.
    for (int i = 0; i < N; i++) begin
      x_valid = 1'b1;
      cyc();
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    for (int i = 0; i < M + 1 + P + 30; i++) cyc();
    #1;
    chk("t5_rd_addr_g1k30", xmem_rd_addr, 46);
    chk("t5_fmem_k30", fmem_rd_addr, 30);
    reset = 1'b1;
    #1;
    chk("t5_rst_x_ready", x_ready, 0);
    chk("t5_rst_y_valid", y_valid, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t5_x_ready", x_ready, 1);
    chk("t5_acc_en", acc_en, 0);
    chk("t5_acc_clr", acc_clr, 0);
    chk("t5_y_valid", y_valid, 0);
    chk("t5_wr_addr", xmem_wr_addr, 0);
    chk("t5_rd_addr", xmem_rd_addr, 0);
    run_vector(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
